// File: rtl/rv32i_types.sv
// Shared RV32I encodings and multicycle-control select/state types.
// Pure declarations: no latency, no flow control.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        ld_lb  = 3'b000,
        ld_lh  = 3'b001,
        ld_lw  = 3'b010,
        ld_lbu = 3'b100,
        ld_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        st_sb = 3'b000,
        st_sh = 3'b001,
        st_sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        pcmux_pc_plus4 = 2'd0,
        pcmux_alu_out  = 2'd1,
        pcmux_alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out = 1'b0,
        alumux1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm   = 3'd0,
        alumux2_u_imm   = 3'd1,
        alumux2_b_imm   = 3'd2,
        alumux2_s_imm   = 3'd3,
        alumux2_j_imm   = 3'd4,
        alumux2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        rfmux_alu_out  = 4'd0,
        rfmux_br_en    = 4'd1,
        rfmux_u_imm    = 4'd2,
        rfmux_lw       = 4'd3,
        rfmux_pc_plus4 = 4'd4,
        rfmux_lb       = 4'd5,
        rfmux_lbu      = 4'd6,
        rfmux_lh       = 4'd7,
        rfmux_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        marmux_pc_out  = 1'b0,
        marmux_alu_out = 1'b1
    } marmux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out = 1'b0,
        cmpmux_i_imm   = 1'b1
    } cmpmux_sel_t;

    typedef enum logic [3:0] {
        s_fetch1, s_fetch2, s_fetch3, s_decode,
        s_imm, s_reg, s_lui, s_auipc, s_br,
        s_calc_addr, s_ld1, s_ld2, s_st1, s_st2,
        s_jal, s_jalr
    } mc_state_t;

    typedef logic [3:0] rv32i_mem_wmask;

    // States that complete an instruction; leaving one of them retires it.
    function automatic logic is_terminal(input mc_state_t s);
        return (s == s_imm) || (s == s_reg) || (s == s_lui) || (s == s_auipc) ||
               (s == s_br) || (s == s_ld2) || (s == s_st2) || (s == s_jal) ||
               (s == s_jalr);
    endfunction

endpackage

// File: rtl/rv32i_mc_wmask.sv
// Store byte-enable generator from funct3 and address LSBs.
// Purely combinational, no flow control.
module rv32i_mc_wmask
    import rv32i_types::*;
(
    input  logic [2:0]     funct3,
    input  logic [1:0]     addr_lsb,
    output rv32i_mem_wmask wmask
);

    always_comb begin
        wmask = 4'b1111;
        case (funct3)
            st_sb:   wmask = 4'b0001 << addr_lsb;
            st_sh:   wmask = 4'b0011 << {addr_lsb[1], 1'b0};
            default: wmask = 4'b1111;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multicycle RV32I control FSM: one state per cycle, outputs combinational from state.
// Memory states hold their strobes until mem_resp; retired count bumps on each terminal state.
module rv32i_mc_control
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    input  logic [1:0]      mem_addr_lsb,
    input  logic            mem_resp,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output pcmux_sel_t      pcmux_sel,
    output alumux1_sel_t    alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output regfilemux_sel_t regfilemux_sel,
    output marmux_sel_t     marmux_sel,
    output cmpmux_sel_t     cmpmux_sel,
    output alu_ops          aluop,
    output branch_funct3_t  cmpop,
    output logic            mem_read,
    output logic            mem_write,
    output rv32i_mem_wmask  mem_byte_enable,
    output logic [CNT_W-1:0] inst_retired
);

    mc_state_t      state, next_state;
    rv32i_mem_wmask st_wmask;
    logic           unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    rv32i_mc_wmask u_wmask (
        .funct3   (funct3),
        .addr_lsb (mem_addr_lsb),
        .wmask    (st_wmask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= s_fetch1;
            inst_retired <= '0;
        end else begin
            state <= next_state;
            if (is_terminal(state)) begin
                inst_retired <= inst_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state      = state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = pcmux_pc_plus4;
        alumux1_sel     = alumux1_rs1_out;
        alumux2_sel     = alumux2_i_imm;
        regfilemux_sel  = rfmux_alu_out;
        marmux_sel      = marmux_pc_out;
        cmpmux_sel      = cmpmux_rs2_out;
        aluop           = alu_add;
        cmpop           = beq;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;

        case (state)
            s_fetch1: begin
                load_mar   = 1'b1;
                next_state = s_fetch2;
            end
            s_fetch2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) next_state = s_fetch3;
            end
            s_fetch3: begin
                load_ir    = 1'b1;
                next_state = s_decode;
            end
            s_decode: begin
                case (opcode)
                    op_imm:            next_state = s_imm;
                    op_reg:            next_state = s_reg;
                    op_lui:            next_state = s_lui;
                    op_auipc:          next_state = s_auipc;
                    op_br:             next_state = s_br;
                    op_load, op_store: next_state = s_calc_addr;
                    op_jal:            next_state = s_jal;
                    op_jalr:           next_state = s_jalr;
                    default:           next_state = s_fetch1;
                endcase
            end
            s_imm, s_reg: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                next_state   = s_fetch1;
                if (state == s_reg) alumux2_sel = alumux2_rs2_out;
                case (funct3)
                    f3_slt, f3_sltu: begin
                        cmpmux_sel     = (state == s_reg) ? cmpmux_rs2_out : cmpmux_i_imm;
                        cmpop          = (funct3 == f3_slt) ? blt : bltu;
                        regfilemux_sel = rfmux_br_en;
                    end
                    f3_sr:   aluop = funct7[5] ? alu_sra : alu_srl;
                    f3_add:  aluop = (state == s_reg && funct7[5]) ? alu_sub : alu_add;
                    default: aluop = alu_ops'(funct3);
                endcase
            end
            s_lui: begin
                regfilemux_sel = rfmux_u_imm;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                next_state     = s_fetch1;
            end
            s_auipc: begin
                alumux1_sel  = alumux1_pc_out;
                alumux2_sel  = alumux2_u_imm;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                next_state   = s_fetch1;
            end
            s_br: begin
                cmpop       = branch_funct3_t'(funct3);
                alumux1_sel = alumux1_pc_out;
                alumux2_sel = alumux2_b_imm;
                pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
                load_pc     = 1'b1;
                next_state  = s_fetch1;
            end
            s_calc_addr: begin
                marmux_sel = marmux_alu_out;
                load_mar   = 1'b1;
                if (opcode == op_store) begin
                    alumux2_sel   = alumux2_s_imm;
                    load_data_out = 1'b1;
                    next_state    = s_st1;
                end else begin
                    next_state    = s_ld1;
                end
            end
            s_ld1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) next_state = s_ld2;
            end
            s_ld2: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                next_state   = s_fetch1;
                case (funct3)
                    ld_lb:   regfilemux_sel = rfmux_lb;
                    ld_lbu:  regfilemux_sel = rfmux_lbu;
                    ld_lh:   regfilemux_sel = rfmux_lh;
                    ld_lhu:  regfilemux_sel = rfmux_lhu;
                    default: regfilemux_sel = rfmux_lw;
                endcase
            end
            s_st1: begin
                mem_write       = 1'b1;
                mem_byte_enable = st_wmask;
                if (mem_resp) next_state = s_st2;
            end
            s_st2: begin
                load_pc    = 1'b1;
                next_state = s_fetch1;
            end
            s_jal: begin
                regfilemux_sel = rfmux_pc_plus4;
                load_regfile   = 1'b1;
                alumux1_sel    = alumux1_pc_out;
                alumux2_sel    = alumux2_j_imm;
                pcmux_sel      = pcmux_alu_out;
                load_pc        = 1'b1;
                next_state     = s_fetch1;
            end
            s_jalr: begin
                pcmux_sel      = pcmux_alu_mod2;
                regfilemux_sel = rfmux_pc_plus4;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                next_state     = s_fetch1;
            end
            default: next_state = s_fetch1;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Bench for rv32i_mc_control: directed vector table, corner sequences, random instruction stream vs. a per-instruction model.
module tb_rv32i_mc_control;

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13,
                           OP_REG = 7'h33, OP_CSR = 7'h73;
    localparam logic [2:0] A_ADD = 3'd0, A_SLL = 3'd1, A_SRA = 3'd2, A_SUB = 3'd3,
                           A_XOR = 3'd4, A_SRL = 3'd5, A_OR = 3'd6, A_AND = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic        br_en = 1'b0, mem_resp = 1'b0;
    logic [1:0]  mem_addr_lsb = '0;
    logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0]  pcmux_sel;
    logic        alumux1_sel, marmux_sel, cmpmux_sel;
    logic [2:0]  alumux2_sel, aluop, cmpop;
    logic [3:0]  regfilemux_sel, mem_byte_enable;
    logic        mem_read, mem_write;
    logic [31:0] inst_retired;

    always #5 clk = ~clk;

    rv32i_mc_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_addr_lsb(mem_addr_lsb), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .inst_retired(inst_retired)
    );

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
        logic [1:0] pcmux;
        logic       alumux1;
        logic [2:0] alumux2;
        logic [3:0] rfmux;
        logic       marmux, cmpmux;
        logic [2:0] aluop, cmpop;
        logic       mem_read, mem_write;
        logic [3:0] be;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       br;
        logic [1:0] lsb;
        int         cyc;
        int         inc;
        logic [3:0] rfmux;  // F = no regfile write
        logic [1:0] pcmux;  // 3 = no pc load
        logic [3:0] be;     // F = no store or full word
        logic [2:0] aluop;  // aluop in the instruction's final cycle
    } vec_t;

    int          checks = 0, errors = 0;
    logic [31:0] exp_cnt = '0;
    ctl_t        exp_q[$];
    bit          resp_q[$], ret_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t c;
        c = '{load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, pcmux_sel,
              alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel, aluop, cmpop,
              mem_read, mem_write, mem_byte_enable};
        return c;
    endfunction

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.be = 4'hF;
        return c;
    endfunction

    function automatic logic [3:0] store_bytes(input logic [2:0] f3, input logic [1:0] lsb);
        int size, off;
        logic [3:0] be;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        off  = (f3 == 3'd0) ? int'(lsb) : (f3 == 3'd1) ? int'(lsb & 2'b10) : 0;
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + size);
        return be;
    endfunction

    function automatic logic [3:0] load_sel(input logic [2:0] f3);
        case (f3)
            3'd0:    return 4'd5;
            3'd1:    return 4'd7;
            3'd4:    return 4'd6;
            3'd5:    return 4'd8;
            default: return 4'd3;
        endcase
    endfunction

    function automatic logic [2:0] arith_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    return (is_reg && alt) ? A_SUB : A_ADD;
            3'd1:    return A_SLL;
            3'd4:    return A_XOR;
            3'd5:    return alt ? A_SRA : A_SRL;
            3'd6:    return A_OR;
            3'd7:    return A_AND;
            default: return A_ADD;
        endcase
    endfunction

    function automatic bit single_cycle(input logic [6:0] op);
        return op == OP_IMM || op == OP_REG || op == OP_LUI || op == OP_AUIPC ||
               op == OP_BR || op == OP_JAL || op == OP_JALR;
    endfunction

    // Outputs of the one execute cycle of a non-memory instruction.
    function automatic ctl_t term(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic br);
        ctl_t c;
        c = idle();
        if (op == OP_IMM || op == OP_REG) begin
            c.load_regfile = 1'b1;
            c.load_pc = 1'b1;
            c.alumux2 = (op == OP_REG) ? 3'd5 : 3'd0;
            if (f3 == 3'd2 || f3 == 3'd3) begin
                c.cmpmux = (op == OP_REG) ? 1'b0 : 1'b1;
                c.cmpop  = (f3 == 3'd2) ? 3'd4 : 3'd6;
                c.rfmux  = 4'd1;
            end else begin
                c.aluop = arith_alu(f3, f7[5], op == OP_REG);
            end
        end else if (op == OP_LUI) begin
            c.rfmux = 4'd2; c.load_regfile = 1'b1; c.load_pc = 1'b1;
        end else if (op == OP_AUIPC) begin
            c.alumux1 = 1'b1; c.alumux2 = 3'd1; c.load_regfile = 1'b1; c.load_pc = 1'b1;
        end else if (op == OP_BR) begin
            c.cmpop = f3; c.alumux1 = 1'b1; c.alumux2 = 3'd2;
            c.pcmux = br ? 2'd1 : 2'd0; c.load_pc = 1'b1;
        end else if (op == OP_JAL) begin
            c.rfmux = 4'd4; c.load_regfile = 1'b1; c.alumux1 = 1'b1; c.alumux2 = 3'd4;
            c.pcmux = 2'd1; c.load_pc = 1'b1;
        end else begin
            c.pcmux = 2'd2; c.rfmux = 4'd4; c.load_regfile = 1'b1; c.load_pc = 1'b1;
        end
        return c;
    endfunction

    function automatic bit spur();
        return $urandom_range(0, 3) == 0;
    endfunction

    task automatic push(input ctl_t c, input bit r, input bit ret);
        exp_q.push_back(c);
        resp_q.push_back(r);
        ret_q.push_back(ret);
    endtask

    // Expected per-cycle outputs, mem_resp to drive, and retire flag for one instruction.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic br, input logic [1:0] lsb, input int lat_f, input int lat_m);
        ctl_t c;
        bit   st;
        c = idle(); c.load_mar = 1'b1; push(c, spur(), 1'b0);
        for (int i = 0; i <= lat_f; i++) begin
            c = idle(); c.mem_read = 1'b1; c.load_mdr = 1'b1; push(c, i == lat_f, 1'b0);
        end
        c = idle(); c.load_ir = 1'b1; push(c, spur(), 1'b0);
        push(idle(), spur(), 1'b0);
        if (op == OP_LOAD || op == OP_STORE) begin
            st = (op == OP_STORE);
            c = idle(); c.load_mar = 1'b1; c.marmux = 1'b1;
            c.alumux2 = st ? 3'd3 : 3'd0; c.load_data_out = st;
            push(c, spur(), 1'b0);
            for (int i = 0; i <= lat_m; i++) begin
                c = idle();
                if (st) begin
                    c.mem_write = 1'b1; c.be = store_bytes(f3, lsb);
                end else begin
                    c.mem_read = 1'b1; c.load_mdr = 1'b1;
                end
                push(c, i == lat_m, 1'b0);
            end
            c = idle(); c.load_pc = 1'b1;
            if (!st) begin
                c.load_regfile = 1'b1; c.rfmux = load_sel(f3);
            end
            push(c, spur(), 1'b1);
        end else if (single_cycle(op)) begin
            push(term(op, f3, f7, br), spur(), 1'b1);
        end
    endtask

    // Entry and exit: low phase of a FETCH1 cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] rf, be;
        logic [1:0] pm;
        logic [2:0] al;
        int len;
        opcode = v.op; funct3 = v.f3; funct7 = v.f7; br_en = v.br; mem_addr_lsb = v.lsb;
        mem_resp = 1'b1;
        rf = 4'hF; pm = 2'd3; be = 4'hF; al = '0; len = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk); #1;
            if (load_mar && marmux_sel == 1'b0) begin
                len = j;
                break;
            end
            if (load_regfile) rf = regfilemux_sel;
            if (load_pc) pm = pcmux_sel;
            if (mem_write) be = mem_byte_enable;
            al = aluop;
        end
        exp_cnt += 32'(v.inc);
        check($sformatf("vec%0d cycles", idx), 64'(len), 64'(v.cyc));
        check($sformatf("vec%0d regfilemux", idx), 64'(rf), 64'(v.rfmux));
        check($sformatf("vec%0d pcmux", idx), 64'(pm), 64'(v.pcmux));
        check($sformatf("vec%0d byte_enable", idx), 64'(be), 64'(v.be));
        check($sformatf("vec%0d aluop", idx), 64'(al), 64'(v.aluop));
        check($sformatf("vec%0d retired", idx), 64'(inst_retired), 64'(exp_cnt));
    endtask

    initial begin
        vec_t vt[$];
        ctl_t got;
        int nrd;
        logic [6:0] ops[11];

        vt.push_back('{OP_IMM,  3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_IMM,  3'd2, 7'h00, 1'b0, 2'd0, 5, 1, 4'd1, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_IMM,  3'd5, 7'h20, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_SRA});
        vt.push_back('{OP_IMM,  3'd5, 7'h00, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_SRL});
        vt.push_back('{OP_REG,  3'd0, 7'h20, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_SUB});
        vt.push_back('{OP_REG,  3'd7, 7'h00, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_AND});
        vt.push_back('{OP_LUI,  3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'd2, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_AUIPC,3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'd0, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_BR,   3'd0, 7'h00, 1'b1, 2'd0, 5, 1, 4'hF, 2'd1, 4'hF, A_ADD});
        vt.push_back('{OP_BR,   3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'hF, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_JAL,  3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'd4, 2'd1, 4'hF, A_ADD});
        vt.push_back('{OP_JALR, 3'd0, 7'h00, 1'b0, 2'd0, 5, 1, 4'd4, 2'd2, 4'hF, A_ADD});
        vt.push_back('{OP_LOAD, 3'd2, 7'h00, 1'b0, 2'd0, 7, 1, 4'd3, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_LOAD, 3'd4, 7'h00, 1'b0, 2'd1, 7, 1, 4'd6, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_LOAD, 3'd1, 7'h00, 1'b0, 2'd2, 7, 1, 4'd7, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_LOAD, 3'd3, 7'h00, 1'b0, 2'd0, 7, 1, 4'd3, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_STORE,3'd0, 7'h00, 1'b0, 2'd2, 7, 1, 4'hF, 2'd0, 4'h4, A_ADD});
        vt.push_back('{OP_STORE,3'd1, 7'h00, 1'b0, 2'd2, 7, 1, 4'hF, 2'd0, 4'hC, A_ADD});
        vt.push_back('{OP_STORE,3'd2, 7'h00, 1'b0, 2'd3, 7, 1, 4'hF, 2'd0, 4'hF, A_ADD});
        vt.push_back('{OP_CSR,  3'd0, 7'h00, 1'b0, 2'd0, 4, 0, 4'hF, 2'd3, 4'hF, A_ADD});
        vt.push_back('{7'h7F,   3'd0, 7'h00, 1'b0, 2'd0, 4, 0, 4'hF, 2'd3, 4'hF, A_ADD});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst load_mar", 64'(load_mar), 64'd1);
        check("rst marmux", 64'(marmux_sel), 64'd0);
        check("rst mem_read", 64'(mem_read), 64'd0);
        check("rst retired", 64'(inst_retired), 64'd0);
        rst_n = 1'b1;

        // addi with a three-cycle fetch
        opcode = OP_IMM; funct3 = 3'd0; funct7 = 7'h00; mem_resp = 1'b0;
        nrd = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk); #1;
            mem_resp = (j == 3);
            if (mem_read) nrd++;
            if (j == 6) begin
                check("addi load_regfile", 64'(load_regfile), 64'd1);
                check("addi aluop", 64'(aluop), 64'(A_ADD));
                check("addi alumux2", 64'(alumux2_sel), 64'd0);
            end
        end
        check("addi mem_read cycles", 64'(nrd), 64'd3);
        exp_cnt += 32'd1;
        @(negedge clk); #1;
        mem_resp = 1'b0;
        check("addi back to fetch", 64'(load_mar && marmux_sel == 1'b0), 64'd1);
        check("addi retired", 64'(inst_retired), 64'(exp_cnt));

        foreach (vt[i]) run_vec(vt[i], i);

        // Random instruction stream
        ops = '{OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_BR, OP_LOAD, OP_STORE, OP_JAL,
                OP_JALR, OP_CSR, 7'h00};
        for (int n = 0; n < 250; n++) begin
            opcode = ops[$urandom_range(0, 10)];
            if (opcode == 7'h00) opcode = 7'($urandom);
            funct3 = 3'($urandom);
            funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
            br_en = 1'($urandom);
            mem_addr_lsb = 2'($urandom);
            model(opcode, funct3, funct7, br_en, mem_addr_lsb,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            for (int k = 0; exp_q.size() > 0; k++) begin
                if (k > 0) begin
                    @(negedge clk); #1;
                end
                mem_resp = resp_q.pop_front();
                got = sample();
                check($sformatf("rand%0d cyc%0d ctl", n, k), 64'(got), 64'(exp_q.pop_front()));
                check($sformatf("rand%0d cyc%0d retired", n, k), 64'(inst_retired), 64'(exp_cnt));
                if (ret_q.pop_front()) exp_cnt += 32'd1;
            end
            @(negedge clk); #1;
        end
        mem_resp = 1'b0;

        // Reset while a load waits in LD1
        opcode = OP_LOAD; funct3 = 3'd2;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk); #1;
            mem_resp = (j == 1);
            if (j == 5) check("ld1 mem_read", 64'(mem_read), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        check("abort mem_read", 64'(mem_read), 64'd0);
        check("abort mem_write", 64'(mem_write), 64'd0);
        check("abort retired", 64'(inst_retired), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort fetch1", 64'(load_mar && marmux_sel == 1'b0), 64'd1);
        @(negedge clk); #1;
        check("abort refetch", 64'(mem_read), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_control.md
Name: rv32i_mc_control

Overview:
Multicycle control FSM for the RV32I datapath. Sequences fetch/decode/execute per instruction and drives every datapath load enable, mux select, ALU/compare op and memory strobe. Sits between the datapath (supplies opcode/funct3/funct7/br_en/address LSBs) and the unified memory port (mem_read/mem_write/mem_resp). Also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  rv32i_opcode from IR
funct3  in  3  from IR
funct7  in  7  from IR (bit 5 selects sub/sra)
br_en  in  1  comparator result
mem_addr_lsb  in  2  MAR[1:0], for byte enables and load extraction
mem_resp  in  1  memory done, single-cycle pulse
load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  datapath register enables
pcmux_sel  out  2  pcmux_sel_t
alumux1_sel  out  1  alumux1_sel_t
alumux2_sel  out  3  alumux2_sel_t
regfilemux_sel  out  4  regfilemux_sel_t
marmux_sel  out  1  marmux_sel_t
cmpmux_sel  out  1  cmpmux_sel_t
aluop  out  3  alu_ops
cmpop  out  3  branch_funct3_t
mem_read, mem_write  out  1 each  memory strobes
mem_byte_enable  out  4  rv32i_mem_wmask
inst_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=FETCH1, inst_retired=0. Outputs are combinational from state (+opcode/funct3/funct7/mem_addr_lsb); every output defaults to 0 (mux sels encoding 0, aluop=alu_add, mem_byte_enable=4'b1111) unless a state overrides.
- States: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, CALC_ADDR, LD1, LD2, ST1, ST2, JAL, JALR.
- FETCH1: load_mar, marmux=pc_out -> FETCH2.
- FETCH2: mem_read=1, load_mdr=1; stay until mem_resp, then FETCH3.
- FETCH3: load_ir -> DECODE.
- DECODE: no enables; next by opcode: op_imm->IMM, op_reg->REG, op_lui->LUI, op_auipc->AUIPC, op_br->BR, op_load/op_store->CALC_ADDR, op_jal->JAL, op_jalr->JALR; op_csr or any other value -> FETCH1 with no state change, not counted as retired.
- IMM: load_regfile, load_pc (pcmux=pc_plus4), alumux1=rs1, alumux2=i_imm. funct3 slt/sltu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en. sr: aluop=alu_sra if funct7[5] else alu_srl. Others: aluop=funct3 mapping, regfilemux=alu_out.
- REG: as IMM with alumux2=rs2_out, cmpmux=rs2_out; add with funct7[5] -> alu_sub.
- LUI: regfilemux=u_imm, load_regfile, load_pc.
- AUIPC: alumux1=pc_out, alumux2=u_imm, alu_add, regfilemux=alu_out, load_regfile, load_pc.
- BR: cmpop=funct3, cmpmux=rs2_out, alumux1=pc_out, alumux2=b_imm, alu_add; pcmux=alu_out if br_en else pc_plus4; load_pc.
- CALC_ADDR: alumux1=rs1, alu_add, marmux=alu_out, load_mar; alumux2=s_imm and load_data_out for op_store -> ST1; i_imm for op_load -> LD1.
- LD1: mem_read, load_mdr; hold until mem_resp -> LD2.
- LD2: load_regfile, load_pc (pc_plus4); regfilemux by funct3: lw, lb, lbu, lh, lhu (extraction uses mem_addr_lsb in datapath). Other funct3 -> treat as lw.
- ST1: mem_write, mem_byte_enable: sb=4'b0001<<lsb, sh=4'b0011<<{lsb[1],0}, sw/other=4'b1111; hold until mem_resp -> ST2.
- ST2: load_pc (pc_plus4).
- JAL: regfilemux=pc_plus4, load_regfile, alumux1=pc_out, alumux2=j_imm, pcmux=alu_out, load_pc.
- JALR: alumux1=rs1, alumux2=i_imm, pcmux=alu_mod2, regfilemux=pc_plus4, load_regfile, load_pc.
- All terminal states (IMM,REG,LUI,AUIPC,BR,LD2,ST2,JAL,JALR) -> FETCH1 and increment inst_retired by 1, wrapping at 2^CNT_W.
- mem_resp outside FETCH2/LD1/ST1 ignored. mem_read/mem_write never both 1; strobes held steady until mem_resp.
- Reset mid-transaction: immediate return to FETCH1, strobes drop asynchronously; memory must tolerate abandoned request.

Decomposition:
- Shared package rv32i_types: add pcmux_sel_t (pc_plus4=0, alu_out=1, alu_mod2=2), alumux1_sel_t (rs1_out=0, pc_out=1), alumux2_sel_t (i_imm=0, u_imm, b_imm, s_imm, j_imm, rs2_out=5), regfilemux_sel_t (alu_out=0, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu=8), marmux_sel_t, cmpmux_sel_t, mc_state_t.
- One sub-module natural: rv32i_mc_wmask (combinational store byte-enable generator from funct3, mem_addr_lsb).

Test Plan:
- Reset held, release -> FETCH1, load_mar=1, marmux=pc_out, inst_retired=0, mem_read=0.
- Fetch addi (op_imm, funct3=000) with mem_resp after 3 cycles -> mem_read high 3 cycles, then FETCH3, DECODE, IMM with load_regfile=1, aluop=alu_add, alumux2=i_imm; inst_retired=1.
- sb with mem_addr_lsb=2'b10 -> ST1 mem_write=1, mem_byte_enable=4'b0100; sh at lsb=2'b10 -> 4'b1100.
- beq with br_en=1 -> pcmux=alu_out; br_en=0 -> pcmux=pc_plus4; both retire.
- opcode=op_csr -> DECODE->FETCH1, no load_regfile/load_pc, inst_retired unchanged.
- rst_n low during LD1 with mem_read=1 -> same cycle mem_read=0, state FETCH1 after release, count=0.
